// File: rtl/syn_access_seq_if.sv
// ---------------------------------------------------------------------------
// syn_access_seq_if
// Bundles the event handshake, the synaptic SRAM control bus and the
// read-data tags of the synaptic row access sequencer.
//
// Signals (direction as seen by the sequencer, modport slave):
//   evt_req                 in   pre-neuron event request, held until evt_ack
//   evt_pre_addr[9:0]       in   pre-neuron row address
//   evt_update              in   1 = read-modify-write row, 0 = read-only row
//   spi_gate_activity_sync  in   blocks acceptance of new events while high
//   evt_ack                 out  one-cycle acceptance pulse
//   busy                    out  a row is in progress
//   done                    out  one-cycle pulse when a row completes
//   ctrl_synarray_cs        out  SRAM chip select
//   ctrl_synarray_we        out  SRAM write enable
//   ctrl_synarray_addr      out  SRAM address {row, word}
//   ctrl_pre_en[7:0]        out  per-weight update enables
//   rdata_valid             out  SRAM read data belongs to last cycle's read
//   rdata_word[2:0]         out  word index of that read data
// The master modport is the mirror image, for the event source / bench.
// ---------------------------------------------------------------------------
interface syn_access_seq_if #(
    parameter int ADDR_W = 13
);
    logic              evt_req;
    logic [9:0]        evt_pre_addr;
    logic              evt_update;
    logic              spi_gate_activity_sync;
    logic              evt_ack;
    logic              busy;
    logic              done;
    logic              ctrl_synarray_cs;
    logic              ctrl_synarray_we;
    logic [ADDR_W-1:0] ctrl_synarray_addr;
    logic [7:0]        ctrl_pre_en;
    logic              rdata_valid;
    logic [2:0]        rdata_word;

    modport slave (
        input  evt_req, evt_pre_addr, evt_update, spi_gate_activity_sync,
        output evt_ack, busy, done, ctrl_synarray_cs, ctrl_synarray_we,
               ctrl_synarray_addr, ctrl_pre_en, rdata_valid, rdata_word
    );

    modport master (
        output evt_req, evt_pre_addr, evt_update, spi_gate_activity_sync,
        input  evt_ack, busy, done, ctrl_synarray_cs, ctrl_synarray_we,
               ctrl_synarray_addr, ctrl_pre_en, rdata_valid, rdata_word
    );
endinterface

// File: rtl/syn_access_seq.sv
// ---------------------------------------------------------------------------
// syn_access_seq
// Walks one pre-neuron row of the synaptic SRAM per accepted event. In
// read-only mode each word is read on consecutive cycles; in update mode
// every read is followed by a write-back of the same address one cycle
// later, when the SDSP-modified data is available.
//
// Ports:
//   clk_i   single clock, rising edge
//   rst_i   asynchronous, active-high reset
//   bus     syn_access_seq_if.slave (event handshake, SRAM control, tags)
//
// Parameters:
//   WORDS_PER_ROW  32-bit words per row, power of two, at most 8
//   ADDR_W         10 + log2(WORDS_PER_ROW)
// ---------------------------------------------------------------------------
module syn_access_seq #(
    parameter int WORDS_PER_ROW = 8,
    parameter int ADDR_W        = 13
) (
    input  logic            clk_i,
    input  logic            rst_i,
    syn_access_seq_if.slave bus
);

    localparam int LOG_W = $clog2(WORDS_PER_ROW);
    localparam int CNT_W = (LOG_W > 0) ? LOG_W : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_ROW - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_FLUSH
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  word_q,  word_d;
    logic [9:0]        row_q,   row_d;
    logic              mode_q,  mode_d;

    logic              cs_q,     cs_d;
    logic              we_q,     we_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [7:0]        pre_en_q, pre_en_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              rvalid_q;
    logic [2:0]        rword_q;

    logic              accept;
    logic              access_d;

    // Acknowledge is combinational so that a request held through a row is
    // accepted in the very first IDLE cycle after FLUSH; the state change
    // itself happens on the following rising edge.
    assign accept = (state_q == ST_IDLE) && bus.evt_req
                    && !bus.spi_gate_activity_sync && !rst_i;

    // NOTE: every variable written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        row_d   = row_q;
        mode_d  = mode_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_READ;
                    row_d   = bus.evt_pre_addr;
                    mode_d  = bus.evt_update;
                    word_d  = '0;
                end
            end
            ST_READ: begin
                if (mode_q) begin
                    state_d = ST_WRITE;
                end else if (word_q == LAST_WORD) begin
                    state_d = ST_FLUSH;
                end else begin
                    word_d  = word_q + 1'b1;
                end
            end
            ST_WRITE: begin
                if (word_q == LAST_WORD) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_READ;
                    word_d  = word_q + 1'b1;
                end
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so they
        // line up with the state they describe without combinational glitches.
        access_d = (state_d == ST_READ) || (state_d == ST_WRITE);
        cs_d     = access_d;
        we_d     = (state_d == ST_WRITE);
        pre_en_d = (state_d == ST_WRITE) ? 8'hFF : 8'h00;
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_FLUSH);
        // Address holds its last value outside of an access.
        addr_d   = access_d ? ((ADDR_W'(row_d) << LOG_W) | ADDR_W'(word_d))
                            : addr_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            row_q    <= '0;
            mode_q   <= 1'b0;
            cs_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            pre_en_q <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rword_q  <= 3'd0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            row_q    <= row_d;
            mode_q   <= mode_d;
            cs_q     <= cs_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            pre_en_q <= pre_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            // Read data appears one cycle after a READ; tag it with that word.
            rvalid_q <= (state_q == ST_READ);
            rword_q  <= 3'(word_q);
        end
    end

    assign bus.evt_ack            = accept;
    assign bus.busy               = busy_q;
    assign bus.done               = done_q;
    assign bus.ctrl_synarray_cs   = cs_q;
    assign bus.ctrl_synarray_we   = we_q;
    assign bus.ctrl_synarray_addr = addr_q;
    assign bus.ctrl_pre_en        = pre_en_q;
    assign bus.rdata_valid        = rvalid_q;
    assign bus.rdata_word         = rword_q;

endmodule

// File: tb/tb_syn_access_seq.sv
// ---------------------------------------------------------------------------
// tb_syn_access_seq
// Directed stimulus pushes the expected SRAM accesses, read-data tags and
// ACK-to-DONE latencies into queues; a negedge monitor pops and compares
// whenever the DUT presents an access, a read-data tag or DONE.
// ---------------------------------------------------------------------------
module tb_syn_access_seq;

    localparam int W  = 8;
    localparam int AW = 13;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    pre_en;
    } access_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    syn_access_seq_if #(.ADDR_W(AW)) bus ();

    syn_access_seq #(
        .WORDS_PER_ROW(W),
        .ADDR_W       (AW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    access_t    acc_q[$];
    logic [2:0] rword_exp_q[$];
    int         lat_q[$];

    int n_checks      = 0;
    int n_fail        = 0;
    int cyc           = 0;
    int last_ack_cyc  = 0;
    int last_done_cyc = 0;
    int done_cnt      = 0;
    int done_target   = 0;
    bit mon_en        = 1'b0;
    access_t exp_acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bus.evt_ack) last_ack_cyc = cyc;
            if (bus.ctrl_synarray_cs) begin
                if (acc_q.size() == 0) begin
                    check("cs_unexpected", bus.ctrl_synarray_cs, 32'd0);
                end else begin
                    exp_acc = acc_q.pop_front();
                    check("access_we", bus.ctrl_synarray_we, exp_acc.we);
                    check("access_addr", bus.ctrl_synarray_addr, exp_acc.addr);
                    check("access_pre_en", bus.ctrl_pre_en, exp_acc.pre_en);
                end
            end else begin
                check("idle_we_pre_en", {bus.ctrl_synarray_we, bus.ctrl_pre_en}, 32'd0);
            end
            if (bus.rdata_valid) begin
                if (rword_exp_q.size() == 0)
                    check("rdata_valid_unexpected", bus.rdata_valid, 32'd0);
                else
                    check("rdata_word", bus.rdata_word, rword_exp_q.pop_front());
            end
            if (bus.done) begin
                if (lat_q.size() == 0)
                    check("done_unexpected", bus.done, 32'd0);
                else
                    check("done_latency", cyc - last_ack_cyc, lat_q.pop_front());
                last_done_cyc = cyc;
                done_cnt++;
            end
        end
    end

    // Queue the expected traffic of one complete row.
    task automatic expect_row(input logic [9:0] row, input logic upd);
        for (int w = 0; w < W; w++) begin
            acc_q.push_back('{we: 1'b0, addr: {row, 3'(w)}, pre_en: 8'h00});
            if (upd)
                acc_q.push_back('{we: 1'b1, addr: {row, 3'(w)}, pre_en: 8'hFF});
            rword_exp_q.push_back(3'(w));
        end
        lat_q.push_back(upd ? (2 * W + 1) : (W + 1));
        done_target++;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [9:0] row, input logic upd, input bit hold);
        bit got;
        int n;
        got = 1'b0;
        n   = 0;
        bus.evt_req      = 1'b1;
        bus.evt_pre_addr = row;
        bus.evt_update   = upd;
        while (!got && n < 40) begin
            @(negedge clk);
            if (bus.evt_ack) got = 1'b1;
            n++;
        end
        check("ack_seen", got, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) bus.evt_req = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt != done_target && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_count", done_cnt, done_target);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit got;
        int n;
        bus.evt_req                = 1'b0;
        bus.evt_pre_addr           = 10'd0;
        bus.evt_update             = 1'b0;
        bus.spi_gate_activity_sync = 1'b0;

        // Reset state; a request during reset must not be acknowledged.
        #2 rst = 1'b1;
        bus.evt_req = 1'b1;
        #20;
        check("rst_ack",      bus.evt_ack, 32'd0);
        check("rst_cs",       bus.ctrl_synarray_cs, 32'd0);
        check("rst_we",       bus.ctrl_synarray_we, 32'd0);
        check("rst_addr",     bus.ctrl_synarray_addr, 32'd0);
        check("rst_pre_en",   bus.ctrl_pre_en, 32'd0);
        check("rst_busy",     bus.busy, 32'd0);
        check("rst_done",     bus.done, 32'd0);
        check("rst_rvalid",   bus.rdata_valid, 32'd0);
        bus.evt_req = 1'b0;
        @(negedge clk);
        #2;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Read-only row 5: addresses 0x0028..0x002F.
        expect_row(10'd5, 1'b0);
        issue(10'd5, 1'b0, 1'b0);
        check("ro_first_addr", bus.ctrl_synarray_addr, 32'h0028);
        check("ro_busy", bus.busy, 32'd1);
        wait_done();

        // Read-modify-write row 3: addresses 0x0018..0x001F.
        expect_row(10'd3, 1'b1);
        issue(10'd3, 1'b1, 1'b0);
        check("rmw_first_addr", bus.ctrl_synarray_addr, 32'h0018);
        check("rmw_first_we", bus.ctrl_synarray_we, 32'd0);
        wait_done();

        // Back-to-back rows 1 and 2 with the request held.
        expect_row(10'd1, 1'b0);
        expect_row(10'd2, 1'b0);
        issue(10'd1, 1'b0, 1'b1);
        bus.evt_pre_addr = 10'd2;
        got = 1'b0;
        n   = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (bus.evt_ack) got = 1'b1;
            n++;
        end
        check("b2b_ack_seen", got, 32'd1);
        check("b2b_ack_gap", cyc - last_done_cyc, 32'd1);
        @(posedge clk);
        #1;
        bus.evt_req = 1'b0;
        wait_done();

        // Gate blocks acceptance; releasing it gives ACK in the next cycle.
        expect_row(10'd7, 1'b0);
        bus.spi_gate_activity_sync = 1'b1;
        bus.evt_req                = 1'b1;
        bus.evt_pre_addr           = 10'd7;
        bus.evt_update             = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("gate_blocks_ack", bus.evt_ack, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.spi_gate_activity_sync = 1'b0;
        @(negedge clk);
        check("ack_after_ungate", bus.evt_ack, 32'd1);
        @(posedge clk);
        #1;
        bus.evt_req = 1'b0;
        wait_done();

        // Gate raised at word 4 must not abort the row.
        expect_row(10'd9, 1'b0);
        issue(10'd9, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("gate_mid_addr", bus.ctrl_synarray_addr, 32'h004C);
        bus.spi_gate_activity_sync = 1'b1;
        wait_done();
        bus.spi_gate_activity_sync = 1'b0;

        // Reset during the WRITE of word 2 of an RMW row on row 4.
        for (int w = 0; w < 3; w++) begin
            acc_q.push_back('{we: 1'b0, addr: {10'd4, 3'(w)}, pre_en: 8'h00});
            acc_q.push_back('{we: 1'b1, addr: {10'd4, 3'(w)}, pre_en: 8'hFF});
            rword_exp_q.push_back(3'(w));
        end
        issue(10'd4, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pre_rst_we", bus.ctrl_synarray_we, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_cs",   bus.ctrl_synarray_cs, 32'd0);
        check("midrst_we",   bus.ctrl_synarray_we, 32'd0);
        check("midrst_busy", bus.busy, 32'd0);
        check("midrst_addr", bus.ctrl_synarray_addr, 32'd0);
        check("midrst_done", bus.done, 32'd0);
        check("midrst_acc_left", acc_q.size(), 32'd0);
        check("midrst_rword_left", rword_exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        expect_row(10'd6, 1'b0);
        issue(10'd6, 1'b0, 1'b0);
        check("post_rst_first_addr", bus.ctrl_synarray_addr, 32'h0030);
        wait_done();

        // Boundary row 1023: 0x1FF8..0x1FFF, then idle with address held.
        expect_row(10'd1023, 1'b0);
        issue(10'd1023, 1'b0, 1'b0);
        check("max_first_addr", bus.ctrl_synarray_addr, 32'h1FF8);
        wait_done();
        repeat (3) @(negedge clk);
        check("max_hold_addr", bus.ctrl_synarray_addr, 32'h1FFF);
        check("max_idle_cs", bus.ctrl_synarray_cs, 32'd0);
        check("max_idle_busy", bus.busy, 32'd0);

        check("end_acc_left", acc_q.size(), 32'd0);
        check("end_rword_left", rword_exp_q.size(), 32'd0);
        check("end_lat_left", lat_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
